// File: rtl/button_event.sv
// Button event detector: turns a debounced level into press/release/long-press/auto-repeat
// pulses, with a held level and a wrapping press counter. All outputs are registered.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 2_000_000,
  parameter int unsigned REPEAT_CYCLES = 400_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [20:0] LongLast   = 21'(LONG_CYCLES - 1);
  localparam logic [20:0] RepeatLast = 21'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StLongHeld} state_e;

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        prev_q;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        rpt_q, rpt_d;
  logic        held_q, held_d;
  logic [7:0]  count_q, count_d;

  // State register; prev_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prev_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= btn_level;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  // Release is tested first so it wins over a threshold reached on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (btn_level && !prev_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end
      end
      StPressed: begin
        if (!btn_level) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLongHeld;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      StLongHeld: begin
        if (!btn_level) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == RepeatLast) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state_q == StIdle) && (state_d == StPressed);
    release_d = (state_q != StIdle) && (state_d == StIdle);
    long_d    = (state_q == StPressed) && (state_d == StLongHeld);
    rpt_d     = (state_q == StLongHeld) && btn_level && (cnt_q == RepeatLast);
    held_d    = (state_d != StIdle);
    count_d   = count_q + {7'd0, press_d};
  end

  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign repeat_pulse     = rpt_q;
  assign held             = held_q;
  assign press_count      = count_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4: stimulus pushes the
// expected pulse events, a negedge monitor pops and compares them as the DUT emits pulses.
module tb_button_event;

  localparam int unsigned LongC   = 8;
  localparam int unsigned RepeatC = 4;

  localparam logic [1:0] KPress   = 2'd0;
  localparam logic [1:0] KRelease = 2'd1;
  localparam logic [1:0] KLong    = 2'd2;
  localparam logic [1:0] KRepeat  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    int unsigned cyc;
    logic [7:0]  cnt;
    logic        held;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_level;
  logic       press_pulse, release_pulse, long_press_pulse, repeat_pulse, held;
  logic [7:0] press_count;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_press = 0;
  int         n_release = 0;
  logic [7:0] exp_count;
  ev_t        exp_q[$];

  button_event #(
    .LONG_CYCLES  (LongC),
    .REPEAT_CYCLES(RepeatC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse),
    .held            (held),
    .press_count     (press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(logic [1:0] kind, int unsigned c, logic [7:0] cnt, logic h);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = cnt;
    e.held = h;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press for h cycles then release; expects a prior sampled btn_level of 0.
  task automatic press_hold(input int h);
    int t;
    t = cyc + 1;
    btn_level = 1'b1;
    exp_count = exp_count + 8'd1;
    push(KPress, t, exp_count, 1'b1);
    if (LongC <= h - 1) begin
      push(KLong, t + LongC, exp_count, 1'b1);
      for (int k = LongC + RepeatC; k <= h - 1; k += RepeatC) push(KRepeat, t + k, exp_count, 1'b1);
    end
    push(KRelease, t + h, exp_count, 1'b0);
    repeat (h) step();
    btn_level = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    int   n;
    ev_t  e;
    logic [1:0] kind;
    n = int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse) + int'(repeat_pulse);
    if (n > 1) chk("pulse_onehot", n, 1);
    if (n >= 1) begin
      kind = press_pulse ? KPress : release_pulse ? KRelease : long_press_pulse ? KLong : KRepeat;
      if (press_pulse) n_press++;
      if (release_pulse) n_release++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_press_count", press_count, e.cnt);
        chk("ev_held", held, e.held);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    btn_level = 1'b1;
    exp_count = 8'd0;
    repeat (3) step();
    chk("reset_pulses", {press_pulse, release_pulse, long_press_pulse, repeat_pulse}, 0);
    chk("reset_held", held, 0);
    chk("reset_count", press_count, 0);

    // Button already high at reset release: no press until a fresh 0->1.
    reset = 1'b0;
    repeat (20) step();
    chk("held_through_reset_held", held, 0);
    chk("held_through_reset_count", press_count, 0);
    btn_level = 1'b0;
    step();
    press_hold(5);
    chk("count_after_first", press_count, 1);

    press_hold(20);
    press_hold(21);
    press_hold(8);  // release on the long-threshold edge
    press_hold(9);  // timing restarts from zero

    // Reset during LONG_HELD aborts without release_pulse.
    begin
      int t;
      t = cyc + 1;
      btn_level = 1'b1;
      exp_count = exp_count + 8'd1;
      push(KPress, t, exp_count, 1'b1);
      push(KLong, t + LongC, exp_count, 1'b1);
      repeat (10) step();
      reset = 1'b1;
      step();
      chk("midhold_reset_pulses",
          {press_pulse, release_pulse, long_press_pulse, repeat_pulse}, 0);
      chk("midhold_reset_held", held, 0);
      chk("midhold_reset_count", press_count, 0);
      reset     = 1'b0;
      exp_count = 8'd0;
      repeat (3) step();
      chk("midhold_no_repress", held, 0);
      btn_level = 1'b0;
      step();
      press_hold(3);
      chk("count_after_midhold_reset", press_count, 1);
    end

    // 256 short presses from reset: counter wraps to zero.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    exp_count = 8'd0;
    step();
    n_press   = 0;
    n_release = 0;
    for (int i = 0; i < 256; i++) begin
      press_hold(1);
      if (i == 254) chk("count_at_255", press_count, 255);
      if (i == 255) chk("count_wrap", press_count, 0);
    end
    repeat (3) step();
    chk("press_events", n_press, 256);
    chk("release_events", n_release, 256);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 2_000_000, is the number of held cycles from press_pulse to long_press_pulse (1 s at 500 ns period); legal range 2..2_097_151.
REQ-002 Parameter REPEAT_CYCLES, default 400_000, is the number of cycles between successive repeat pulses (0.2 s); legal range 2..2_097_151.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_level  input  1  debounced button level, synchronous to clk; 1 = pressed.
REQ-006 press_pulse  output  1  one-cycle pulse per detected press.
REQ-007 release_pulse  output  1  one-cycle pulse per detected release.
REQ-008 long_press_pulse  output  1  one-cycle pulse when a press has been held LONG_CYCLES.
REQ-009 repeat_pulse  output  1  one-cycle auto-repeat pulse while the button is held past long press.
REQ-010 held  output  1  level; 1 while the FSM is in PRESSED or LONG_HELD.
REQ-011 press_count  output  8  count of press_pulse events, modulo 256.

Function
REQ-012 All outputs shall be registered; no combinational path from btn_level to any output.
REQ-013 The block shall keep prev_level, the btn_level value sampled at the previous edge.
REQ-014 The FSM shall have the states IDLE, PRESSED and LONG_HELD, plus a 21-bit cycle counter cnt.
REQ-015 IDLE: btn_level=1 with prev_level=0 -> PRESSED, cnt<=0, press_pulse<=1, press_count<=press_count+1; otherwise remain in IDLE.
REQ-016 PRESSED: btn_level=1 with cnt==LONG_CYCLES-1 -> LONG_HELD, cnt<=0, long_press_pulse<=1; btn_level=1 otherwise -> cnt<=cnt+1.
REQ-017 LONG_HELD: btn_level=1 with cnt==REPEAT_CYCLES-1 -> cnt<=0, repeat_pulse<=1; btn_level=1 otherwise -> cnt<=cnt+1.
REQ-018 PRESSED or LONG_HELD with btn_level=0 -> IDLE, cnt<=0, release_pulse<=1.
REQ-019 A release shall take priority over a long or repeat threshold reached on the same edge; only release_pulse is asserted.
REQ-020 Latency: press_pulse shall be high in the cycle after the edge that samples the rising btn_level.
REQ-021 long_press_pulse shall occur exactly LONG_CYCLES cycles after press_pulse.
REQ-022 repeat pulses shall occur at LONG_CYCLES + n*REPEAT_CYCLES cycles after press_pulse, for n = 1, 2, ...
REQ-023 Each pulse output shall be high for exactly one cycle per event and low in all other cycles.
REQ-024 At most one of press_pulse, release_pulse, long_press_pulse and repeat_pulse shall be high in any cycle.
REQ-025 held shall rise in the same cycle as press_pulse and fall in the same cycle as release_pulse.
REQ-026 press_count shall wrap from 255 to 0 without any flag.
REQ-027 A button already high when reset is released shall not produce a press; a press requires a 0->1 transition of btn_level.

Reset
REQ-028 While reset=1 at an edge, the block shall set state=IDLE, cnt=0, prev_level=1, press_count=0, held=0 and every pulse output to 0.
REQ-029 Reset shall take priority over all other inputs.
REQ-030 A reset mid-hold shall abort the hold silently: no release_pulse is generated, and a fresh 0->1 transition is needed to press again.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4 unless stated)
REQ-031 Reset released with btn_level=1 held for 20 cycles -> no pulses and held=0; then btn_level 0 for 1 cycle and back to 1 -> press_pulse for one cycle and press_count=1.
REQ-032 Press held 5 cycles then released -> press_pulse at cycle t, release_pulse at t+5, long_press_pulse never asserted, held high for cycles t..t+4.
REQ-033 Press held 20 cycles -> long_press_pulse at t+8, repeat_pulse at t+12, t+16 and t+20 only if still held, then release_pulse on release.
REQ-034 btn_level dropped on the edge where cnt==7 in PRESSED -> release_pulse only, no long_press_pulse; next press restarts timing from 0.
REQ-035 reset asserted at t+10 during LONG_HELD -> all outputs 0 next cycle, no release_pulse; a later press gives press_count=1.
REQ-036 256 short presses from reset -> press_count reads 255 after press 255 and 0 after press 256; exactly 256 press_pulse and 256 release_pulse events.
